// File: rtl/rx_pair_framer.sv
// ============================================================================
// Module   : rx_pair_framer
// Purpose  : Frames a serial hard-decision bit stream into 2-bit symbols with
//            an end-of-frame mark, buffered in a fall-through output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_pair_framer #(
    parameter int FRAME_PAIRS = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       sof,
    output logic       bit_ready,
    output logic [1:0] rx_pair,
    output logic       pair_valid,
    input  logic       pair_ready,
    output logic       pair_last,
    output logic       frame_err
);

    localparam int                c_PW   = $clog2(FIFO_DEPTH);
    localparam int                c_CW   = $clog2(FRAME_PAIRS);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(FRAME_PAIRS - 1);
    localparam logic [c_PW:0]     c_FULL = (c_PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_SECOND = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_pair_cnt;
    logic              r_first;
    logic              r_run;
    logic              r_frame_err;
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_PW:0]     r_count;
    logic [2:0]        r_mem [FIFO_DEPTH];

    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_push_last;
    logic [2:0]        w_head;

    // r_run holds bit_ready low until the first edge after reset release
    assign bit_ready   = r_run && (r_count != c_FULL);
    assign pair_valid  = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign rx_pair     = pair_valid ? w_head[1:0] : 2'b00;
    assign pair_last   = pair_valid ? w_head[2]   : 1'b0;
    assign frame_err   = r_frame_err;

    assign w_accept    = bit_valid && bit_ready;
    assign w_push      = w_accept && !sof && (r_state == S_SECOND);
    assign w_pop       = pair_valid && pair_ready;
    assign w_push_last = (r_pair_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pair_cnt  <= '0;
            r_first     <= 1'b0;
            r_run       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            r_frame_err <= 1'b0;
            if (w_accept) begin
                if (sof) begin
                    // A sof inside a frame aborts it, including a would-be final pair
                    r_frame_err <= (r_state != S_IDLE);
                    r_first     <= bit_in;
                    r_pair_cnt  <= '0;
                    r_state     <= S_SECOND;
                end else begin
                    case (r_state)
                        S_FIRST: begin
                            r_first <= bit_in;
                            r_state <= S_SECOND;
                        end
                        S_SECOND: begin
                            if (w_push_last) begin
                                r_pair_cnt <= '0;
                                r_state    <= S_IDLE;
                            end else begin
                                r_pair_cnt <= r_pair_cnt + 1'b1;
                                r_state    <= S_FIRST;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_push_last, r_first, bit_in};
        end
    end

endmodule

`default_nettype wire
